// File: rtl/mult_seq_ctrl.sv
// Multi-cycle unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier controller.
// One ripple adder is reused across WIDTH iterations; HI/LO hold the product.
module mult_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    // Ripple-carry adder with carry-in tied to 0; it only ever adds the
    // multiplicand (or zero) onto the running upper half.
    always_comb begin : adder_32bit_i
        logic carry;
        add_b   = lo_q[0] ? mcand_q : '0;
        add_sum = '0;
        carry   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            add_sum[i] = hi_q[i] ^ add_b[i] ^ carry;
            carry      = (hi_q[i] & add_b[i]) | (carry & (hi_q[i] ^ add_b[i]));
        end
        add_cout = carry;
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        count_d = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_RUN;
                    hi_d    = '0;
                    lo_d    = multiplier;
                    mcand_d = multiplicand;
                    count_d = '0;
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    hi_d    = '0;
                    lo_d    = '0;
                    count_d = '0;
                end else begin
                    // Carry-out lands in hi[MSB]: a 65-bit right shift by one.
                    {hi_d, lo_d} = {add_cout, add_sum, lo_q[WIDTH-1:1]};
                    count_d      = count_q + CNT_W'(1);
                    if (count_q == LAST_ITER) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                if (start && !abort) begin
                    state_d = S_RUN;
                    hi_d    = '0;
                    lo_d    = multiplier;
                    mcand_d = multiplicand;
                    count_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see pre-edge values of each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: latency, products, ignored start, abort,
// back-to-back start and asynchronous reset mid-multiply.
module tb_mult_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run    = 0;
    int tests_failed = 0;

    mult_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accept a start at the next edge (edge 0), then scramble the operand
    // inputs so only the captured copies can produce the right product.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    // Expect n consecutive RUN cycles with busy=1 and done=0.
    task automatic run_cycles(input int n, input string tag);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
            tick();
        end
        check({tag, " busy held, no done while running"}, {63'd0, bad}, 64'd0);
    endtask

    // Expect done never to pulse over n cycles.
    task automatic no_done(input int n, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (done !== 1'b0) seen = 1'b1;
            tick();
        end
        check({tag, " no done pulse"}, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #12;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi/lo", {hi, lo}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: 3 x 5, busy cycles 1..32, done at 33
        start_op(32'd3, 32'd5);
        run_cycles(32, "t1");
        check("t1 done at cycle 33", {63'd0, done}, 64'd1);
        check("t1 busy low in done", {63'd0, busy}, 64'd0);
        check("t1 product", {hi, lo}, 64'h0000_0000_0000_000F);
        tick();
        check("t1 done is one pulse", {63'd0, done}, 64'd0);
        check("t1 product held", {hi, lo}, 64'h0000_0000_0000_000F);

        // 2: all-ones squared
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_cycles(32, "t2");
        check("t2 done", {63'd0, done}, 64'd1);
        check("t2 product", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        tick();

        // 3: start in RUN at cycle 5 is ignored
        start_op(32'h8000_0000, 32'd2);
        run_cycles(4, "t3a");
        multiplicand = 32'd7;
        multiplier   = 32'd7;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        run_cycles(27, "t3b");
        check("t3 done at cycle 33", {63'd0, done}, 64'd1);
        check("t3 product ignores start", {hi, lo}, 64'h0000_0001_0000_0000);
        tick();

        // 4: abort at cycle 10
        start_op(32'h1234_5678, 32'h9ABC_DEF0);
        run_cycles(9, "t4");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4 idle after abort", {63'd0, busy}, 64'd0);
        check("t4 hi/lo cleared", {hi, lo}, 64'd0);
        no_done(40, "t4");
        // abort together with start in IDLE: nothing loads
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        start        = 1'b1;
        abort        = 1'b1;
        tick();
        start        = 1'b0;
        abort        = 1'b0;
        check("t4 abort beats start", {62'd0, busy, done}, 64'd0);
        start_op(32'd6, 32'd7);
        run_cycles(32, "t4b");
        check("t4 new product", {hi, lo}, 64'h0000_0000_0000_002A);
        tick();

        // 5: back-to-back start held in DONE
        start_op(32'd4, 32'd4);
        run_cycles(32, "t5a");
        check("t5 first done", {63'd0, done}, 64'd1);
        check("t5 first product", {hi, lo}, 64'h0000_0000_0000_0010);
        multiplicand = 32'd2;
        multiplier   = 32'd3;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        run_cycles(32, "t5b");
        check("t5 second done 33 later", {63'd0, done}, 64'd1);
        check("t5 second product", {hi, lo}, 64'h0000_0000_0000_0006);
        tick();

        // 6: asynchronous reset at cycle 15
        start_op(32'hFFFF_FFFF, 32'h7777_7777);
        run_cycles(14, "t6");
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 async reset outputs", {hi, lo}, 64'd0);
        check("t6 async reset busy/done", {62'd0, busy, done}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        no_done(40, "t6");
        start_op(32'hDEAD_BEEF, 32'h0000_0010);
        run_cycles(32, "t6b");
        check("t6 product after reset", {hi, lo}, 64'h0000_000D_EADB_EEF0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
